serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit unsigned subtractor computing D = A - B, LSB first, one bit per clock, using a single borrow flop.
- Counterpart to the parallel ripple adder in the DigitalSine datapath: it computes the descending-half codes, i.e. the reference amplitude minus the step.
- Trades latency for area: one full-subtractor cell plus shift registers, with a start/busy/done handshake toward the sine sequencer.

Parameters:
- WIDTH, 7, operand and result width in bits (minimum 2).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse; sampled only when not busy.
- a  in  WIDTH  minuend; captured on the accepting edge.
- b  in  WIDTH  subtrahend; captured on the accepting edge.
- busy  out  1  high while the serial operation is in progress.
- done  out  1  one-cycle pulse; d and borrow are valid from this cycle onward.
- d  out  WIDTH  result register; holds the last result until the next completion.
- borrow  out  1  final borrow-out, 1 iff a < b (unsigned); held with d.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; busy=0, done=0, d=0, borrow=0; internal shift registers, bit counter and borrow flop cleared.
- States:
  - IDLE: start=1 captures a and b into shift registers, clears the borrow flop, sets bit count=0, goes to SHIFT.
  - SHIFT: each edge processes bit 0 of the shift registers:
    - diff = a0 ^ b0 ^ br
    - br' = (~a0 & b0) | (~(a0 ^ b0) & br)
    - diff shifts into the result shift register from the MSB side; operand registers shift right; count increments.
    - On the edge processing bit WIDTH-1: load d from the completed shift register, load borrow from br', go to DONE.
  - DONE: done=1 for exactly this cycle.
    - start=1 here is accepted (back-to-back): new operands captured, go to SHIFT.
    - Otherwise go to IDLE.
- busy = 1 in SHIFT, 0 in IDLE and DONE.
- Latency: start accepted at edge E0; busy high after E0 through edge E0+WIDTH; done high in the cycle following edge E0+WIDTH.
- Throughput: one result per WIDTH+1 cycles.
- start in SHIFT is ignored; it is not queued.
- a and b may change freely after the accepting edge.
- d and borrow change only at completion and stay stable during busy, so the consumer may read the previous result while a new operation runs.
- Arithmetic: modulo 2^WIDTH wrap-around. Examples: 0-1 gives d = all-ones, borrow=1. a==b gives d=0, borrow=0.
- Reset mid-operation aborts; no done pulse; outputs return to reset values.

Optional Feature:
- SERIAL_SUBTRACTOR_SAT_EN defined: at completion, if the final borrow is 1, d loads 0 (floor clamp for the sine amplitude); borrow is still reported as 1.
- Undefined: d loads the wrapped modulo result.

Decomposition:
- Shared package (digital_sine_pkg):
  - state enum: IDLE, SHIFT, DONE
  - DS_WIDTH = 7 default
  - counter-width constant, $clog2(WIDTH)
- Natural sub-module: serial_sub_cell, a combinational 1-bit full subtractor (a, b, bin -> diff, bout), instantiated once.

Test Plan:
- a=45, b=12, start pulse -> busy for 7 cycles, done in cycle 8 after the accept edge, d=33, borrow=0.
- a=5, b=9 -> d=124, borrow=1; with SERIAL_SUBTRACTOR_SAT_EN -> d=0, borrow=1.
- Boundaries: a=127, b=127 -> d=0, borrow=0; a=0, b=127 -> d=1, borrow=1; a=127, b=0 -> d=127.
- Back-to-back: start held high across DONE with a=100, b=1, then a=10, b=20:
  - done pulses twice, 8 cycles apart
  - d=99 then 118, borrow 0 then 1
  - d holds 99 throughout the second busy window.
- start pulsed mid-SHIFT with different operands -> ignored; result matches the first operands.
- rst_n low at bit 3 of a=60, b=7 (previous d=33) -> immediately busy=0, done=0, d=0, borrow=0. Next start with a=60, b=7 -> d=53.

Source files
------------

// File: rtl/digital_sine_pkg.sv
// Shared DigitalSine types and constants: sequencer-facing FSM states and default datapath width.
package digital_sine_pkg;

   localparam int DS_WIDTH = 7;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Bit-counter width for a given operand width; never below 1 bit.
   function automatic int cnt_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/serial_sub_cell.sv
// One-bit full subtractor: diff = a - b - bin, bout set when the column needs a borrow.
// Purely combinational; no latency, no flow control.
module serial_sub_cell (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic diff,
   output logic bout
);

   assign diff = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor d = a - b, LSB first; SERIAL_SUBTRACTOR_SAT_EN clamps negative results to 0.
// Latency WIDTH+1 cycles accept-to-done; start is ignored while busy, and is accepted back-to-back in DONE.
module serial_subtractor
   import digital_sine_pkg::*;
#(
   parameter int WIDTH = DS_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] d,
   output logic             borrow
);

   localparam int CW = cnt_width(WIDTH);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] r_sh_q, r_sh_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             br_q, br_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic             borrow_q, borrow_d;

   logic             diff;
   logic             bout;
   logic [WIDTH-1:0] r_next;

   serial_sub_cell u_cell (
      .a    (a_sh_q[0]),
      .b    (b_sh_q[0]),
      .bin  (br_q),
      .diff (diff),
      .bout (bout)
   );

   assign r_next = {diff, r_sh_q[WIDTH-1:1]};

   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      r_sh_d   = r_sh_q;
      cnt_d    = cnt_q;
      br_d     = br_q;
      d_d      = d_q;
      borrow_d = borrow_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_sh_d  = a;
               b_sh_d  = b;
               br_d    = 1'b0;
               cnt_d   = '0;
               state_d = SHIFT;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            r_sh_d = r_next;
            a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
            br_d   = bout;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
               // Final column: the shift register only becomes complete with this edge's diff bit.
`ifdef SERIAL_SUBTRACTOR_SAT_EN
               d_d = bout ? '0 : r_next;
`else
               d_d = r_next;
`endif
               borrow_d = bout;
               state_d  = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         r_sh_q   <= '0;
         cnt_q    <= '0;
         br_q     <= 1'b0;
         d_q      <= '0;
         borrow_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         r_sh_q   <= r_sh_d;
         cnt_q    <= cnt_d;
         br_q     <= br_d;
         d_q      <= d_d;
         borrow_q <= borrow_d;
      end
   end

   assign busy   = (state_q == SHIFT);
   assign done   = (state_q == DONE);
   assign d      = d_q;
   assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=7); expected results hand-computed, SAT build honoured.
module tb_serial_subtractor;

   localparam int W = 7;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] d;
   logic         borrow;

   int checks = 0;
   int errors = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .d      (d),
      .borrow (borrow)
   );

   always #5 clk = ~clk;

   function automatic int exp_d(input int wrapped, input int br);
`ifdef SERIAL_SUBTRACTOR_SAT_EN
      return (br != 0) ? 0 : wrapped;
`else
      return wrapped;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Waits (bounded) for done; n counts negedges sampled since the call, bcnt the busy samples.
   task automatic wait_done(output int n, output int bcnt);
      n = 0;
      bcnt = 0;
      do begin
         @(negedge clk);
         n++;
         if (busy === 1'b1) bcnt++;
      end while (done !== 1'b1 && n < 20);
   endtask

   // Called at a negedge; operands are scrambled after the accept edge to prove they were captured.
   task automatic run_op(input string tag, input int ai, input int bi, input int wrapped, input int br);
      int n, bcnt;
      a = W'(ai);
      b = W'(bi);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      a = ~a;
      b = ~b;
      wait_done(n, bcnt);
      chk({tag, "_lat"}, n, 8);
      chk({tag, "_busy"}, bcnt, 7);
      chk({tag, "_d"}, d, exp_d(wrapped, br));
      chk({tag, "_borrow"}, borrow, br);
   endtask

   initial begin
      int n, bcnt, hold_bad, done_cnt;

      rst_n = 1'b0;
      start = 1'b0;
      a = '0;
      b = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_d", d, 0);
      chk("rst_borrow", borrow, 0);
      rst_n = 1'b1;
      @(negedge clk);

      run_op("sub45_12", 45, 12, 33, 0);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("idle_after_done", busy, 0);

      run_op("sub5_9", 5, 9, 124, 1);
      run_op("sub127_127", 127, 127, 0, 0);
      run_op("sub0_127", 0, 127, 1, 1);
      run_op("sub127_0", 127, 0, 127, 0);
      run_op("sub0_1", 0, 1, 127, 1);

      // Back-to-back: start held through DONE.
      @(negedge clk);
      a = 7'd100;
      b = 7'd1;
      start = 1'b1;
      @(posedge clk);
      #1;
      a = 7'd10;
      b = 7'd20;
      wait_done(n, bcnt);
      chk("b2b1_lat", n, 8);
      chk("b2b1_d", d, 99);
      chk("b2b1_borrow", borrow, 0);
      n = 0;
      hold_bad = 0;
      do begin
         @(negedge clk);
         n++;
         if (done !== 1'b1 && (d !== 7'd99 || busy !== 1'b1)) hold_bad++;
      end while (done !== 1'b1 && n < 20);
      start = 1'b0;
      chk("b2b_spacing", n, 8);
      chk("b2b_hold99", hold_bad, 0);
      chk("b2b2_d", d, exp_d(118, 1));
      chk("b2b2_borrow", borrow, 1);

      // start during SHIFT must be dropped, not queued.
      @(negedge clk);
      a = 7'd50;
      b = 7'd8;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      start = 1'b1;
      a = 7'd1;
      b = 7'd2;
      @(negedge clk);
      start = 1'b0;
      wait_done(n, bcnt);
      chk("ign_lat", n, 4);
      chk("ign_d", d, 42);
      chk("ign_borrow", borrow, 0);
      @(negedge clk);
      chk("ign_not_queued_busy", busy, 0);
      chk("ign_not_queued_done", done, 0);

      // Reset in the middle of an operation.
      run_op("pre_rst", 45, 12, 33, 0);
      @(negedge clk);
      a = 7'd60;
      b = 7'd7;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk("pre_abort_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_d", d, 0);
      chk("abort_borrow", borrow, 0);
      @(negedge clk);
      rst_n = 1'b1;
      done_cnt = 0;
      repeat (10) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) done_cnt++;
      end
      chk("abort_no_done", done_cnt, 0);
      run_op("sub60_7", 60, 7, 53, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
